// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame sequencing, LSB-first serializer and parity generator
// driving the TX_mux select lines. One clk cycle per bit period.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [2:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] SEL_START  = 3'b000;
  localparam logic [2:0] SEL_IDLE   = 3'b001;
  localparam logic [2:0] SEL_DATA   = 3'b010;
  localparam logic [2:0] SEL_PARITY = 3'b011;
  localparam logic [2:0] SEL_STOP   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;

    unique case (state_q)
      S_IDLE, S_STOP: begin
        state_d = S_IDLE;
        // Accepting in STOP gives back-to-back frames with no idle bit between them.
        if (data_valid) begin
          state_d   = S_START;
          shift_d   = p_data;
          par_bit_d = (^p_data) ^ par_typ;
          par_en_d  = par_en;
          cnt_d     = '0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mux_sel = SEL_IDLE;
    unique case (state_q)
      S_IDLE:   mux_sel = SEL_IDLE;
      S_START:  mux_sel = SEL_START;
      S_DATA:   mux_sel = SEL_DATA;
      S_PARITY: mux_sel = SEL_PARITY;
      S_STOP:   mux_sel = SEL_STOP;
      default:  mux_sel = SEL_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shapes, parity, back-to-back, ignored words, reset abort.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [2:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},  {29'd0, mux_sel}, 32'h1);
    chk({tag, "_busy"}, {31'd0, busy},    32'h0);
  endtask

  // Called at the negedge of the START cycle; returns at the negedge of the STOP cycle.
  // With disturb set, a 0xFF word is offered and par_en/par_typ flip during data bit 3.
  task automatic frame_check(input logic [7:0] d, input logic pe, input logic pb,
                             input bit disturb);
    int   nb;
    logic pe_save, pt_save;
    pe_save = par_en;
    pt_save = par_typ;
    nb = 0;
    chk("start_sel",  {29'd0, mux_sel}, 32'h0);
    chk("start_busy", {31'd0, busy},    32'h1);
    if (busy) nb++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (disturb && i == 3) begin
        p_data     = 8'hFF;
        data_valid = 1'b1;
        par_en     = ~pe_save;
        par_typ    = ~pt_save;
      end
      if (disturb && i == 4) begin
        data_valid = 1'b0;
        par_en     = pe_save;
        par_typ    = pt_save;
      end
      chk("data_sel", {29'd0, mux_sel},  32'h2);
      chk("data_bit", {31'd0, ser_data}, {31'd0, d[i]});
      if (busy) nb++;
    end
    if (pe) begin
      tick();
      chk("par_sel", {29'd0, mux_sel}, 32'h3);
      chk("par_bit", {31'd0, par_bit}, {31'd0, pb});
      if (busy) nb++;
    end
    tick();
    chk("stop_sel", {29'd0, mux_sel}, 32'h4);
    if (busy) nb++;
    chk("busy_len", nb, pe ? 32'd11 : 32'd10);
  endtask

  initial begin
    rst        = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_ser", {31'd0, ser_data}, 32'h0);
    chk("rst_par", {31'd0, par_bit},  32'h0);
    rst = 1'b1;
    tick();
    chk_idle("idle");

    // 0xA5 without parity
    accept(8'hA5, 1'b0, 1'b0);
    frame_check(8'hA5, 1'b0, 1'b0, 1'b0);
    tick();
    chk_idle("t1_end");

    // 0xA5 even then odd parity
    accept(8'hA5, 1'b1, 1'b0);
    frame_check(8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    chk_idle("t2e_end");
    accept(8'hA5, 1'b1, 1'b1);
    frame_check(8'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    chk_idle("t2o_end");

    // 0x01 even parity, par_typ/par_en flipped mid-DATA must not matter
    accept(8'h01, 1'b1, 1'b0);
    frame_check(8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    chk_idle("t3_end");

    // back-to-back 0x3C then 0xC3
    accept(8'h3C, 1'b0, 1'b0);
    frame_check(8'h3C, 1'b0, 1'b0, 1'b0);
    p_data     = 8'hC3;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    frame_check(8'hC3, 1'b0, 1'b0, 1'b0);
    tick();
    chk_idle("t4_end");

    // 0x00 frame with 0xFF offered during DATA
    accept(8'h00, 1'b0, 1'b0);
    frame_check(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk_idle("t5_end");

    // reset during data bit 3 of a 0x5A odd-parity frame (par_bit=1 before reset)
    accept(8'h5A, 1'b1, 1'b1);
    chk("t6_pre_par", {31'd0, par_bit}, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_in_data", {29'd0, mux_sel}, 32'h2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_idle("t6_rst");
    chk("t6_ser", {31'd0, ser_data}, 32'h0);
    chk("t6_par", {31'd0, par_bit},  32'h0);
    tick();
    chk_idle("t6_hold");
    accept(8'h96, 1'b1, 1'b1);
    frame_check(8'h96, 1'b1, 1'b1, 1'b0);
    tick();
    chk_idle("t6_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
